rx_pkt_scheduler: RTL and testbench

- Decides which RX source FIFO the packet builder drains next and when it may start.
- Sources are NUM_CHAN data-channel FIFOs (indices 0..NUM_CHAN-1) plus the RX command FIFO (index NUM_CHAN).
- Sits between the per-channel fifo_1kx16 status signals and packet_builder, in the rxclk domain inside the RX inband buffer.
- Issues one grant per packet and waits for the builder's completion handshake. Provides command-channel priority with starvation protection for data channels, and a stall watchdog.

---
 rtl/rx_pkt_scheduler_if.sv | 29 ++
 rtl/rx_pkt_scheduler.sv | 160 ++++++++++++++++
 tb/tb_rx_pkt_scheduler.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_pkt_scheduler_if.sv
// Handshake bundle between the RX source FIFOs, the scheduler and packet_builder.
// The master side drives FIFO status and builder completion; the slave side is the scheduler.
interface rx_pkt_scheduler_if #(
    parameter int NUM_CHAN = 1
);
    logic                         enable;
    logic                         have_space;
    logic [10*(NUM_CHAN+1)-1:0]   chan_usedw;
    logic [NUM_CHAN:0]            chan_empty;
    logic                         pkt_done;
    logic                         clear_status;
    logic [3:0]                   rd_select;
    logic                         pkt_start;
    logic [8:0]                   pkt_len;
    logic [4:0]                   pkt_chan;
    logic                         busy;
    logic                         timeout_err;
    logic [7:0]                   debug;

    modport master (
        output enable, have_space, chan_usedw, chan_empty, pkt_done, clear_status,
        input  rd_select, pkt_start, pkt_len, pkt_chan, busy, timeout_err, debug
    );

    modport slave (
        input  enable, have_space, chan_usedw, chan_empty, pkt_done, clear_status,
        output rd_select, pkt_start, pkt_len, pkt_chan, busy, timeout_err, debug
    );
endinterface

// File: rtl/rx_pkt_scheduler.sv
// Picks the next RX source (data channels round-robin, command with bounded burst priority)
// for packet_builder, issues one start per packet and watches for a stalled builder.
module rx_pkt_scheduler #(
    parameter int NUM_CHAN      = 1,
    parameter int PAYLOAD_WORDS = 252,
    parameter int CMD_BURST_MAX = 4,
    parameter int TIMEOUT       = 1023
) (
    input logic                rxclk,
    input logic                reset,
    rx_pkt_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_rr_ptr;
    logic [2:0] r_cmd_burst;
    logic [9:0] r_wd;
    logic       r_hold;
    logic [3:0] r_rd_select;
    logic [8:0] r_pkt_len;
    logic [4:0] r_pkt_chan;
    logic       r_timeout_err;

    logic [3:0] w_data_elig;
    logic       w_any_data;
    logic       w_cmd_elig;
    logic [9:0] w_cmd_usedw;
    logic [8:0] w_cmd_len;
    logic       w_go;
    logic       w_grant;
    logic       w_grant_cmd;
    logic       w_rr_found;
    logic [1:0] w_rr_idx;
    logic [1:0] w_rr_nxt;
    logic [2:0] w_probe;
    logic       w_wd_expire;
    logic       w_unused_empty;

    // Data-channel empty flags are redundant: usedw alone decides data eligibility.
    assign w_unused_empty = |bus.chan_empty[NUM_CHAN-1:0];

    for (genvar k = 0; k < 4; k++) begin : g_elig
        if (k < NUM_CHAN) begin : g_used
            assign w_data_elig[k] = bus.chan_usedw[10*k +: 10] >= 10'(PAYLOAD_WORDS);
        end else begin : g_unused
            assign w_data_elig[k] = 1'b0;
        end
    end

    assign w_any_data  = |w_data_elig;
    assign w_cmd_usedw = bus.chan_usedw[10*NUM_CHAN +: 10];
    assign w_cmd_elig  = ~bus.chan_empty[NUM_CHAN];
    assign w_go        = bus.enable & bus.have_space;
    assign w_grant_cmd = w_cmd_elig & ((int'(r_cmd_burst) < CMD_BURST_MAX) | ~w_any_data);
    assign w_rr_nxt    = (int'(w_rr_idx) >= NUM_CHAN - 1) ? 2'd0 : w_rr_idx + 2'd1;
    assign w_wd_expire = (r_state == WAIT) && (r_wd == 10'(TIMEOUT - 1)) && !bus.pkt_done;

    always_comb begin
        if (w_cmd_usedw >= 10'(PAYLOAD_WORDS)) begin
            w_cmd_len = 9'(PAYLOAD_WORDS);
        end else if (w_cmd_usedw == 10'd0) begin
            w_cmd_len = 9'd1;
        end else begin
            w_cmd_len = w_cmd_usedw[8:0];
        end
    end

    // Search starts at rr_ptr and wraps, so the last-served channel is tried last.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = 2'd0;
        w_probe    = 3'd0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            w_probe = {1'b0, r_rr_ptr} + 3'(i);
            if (w_probe >= 3'(NUM_CHAN)) begin
                w_probe = w_probe - 3'(NUM_CHAN);
            end
            if (!w_rr_found && w_data_elig[w_probe[1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_probe[1:0];
            end
        end
    end

    // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            IDLE:  if (w_go) w_state_nxt = ARB;
            ARB: begin
                if (!w_go) begin
                    w_state_nxt = IDLE;
                end else if (w_grant_cmd || w_rr_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: w_state_nxt = WAIT;
            WAIT:  if (bus.pkt_done || w_wd_expire) w_state_nxt = HOLD;
            HOLD:  if (r_hold) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rxclk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= 2'd0;
            r_cmd_burst   <= 3'd0;
            r_wd          <= 10'd0;
            r_hold        <= 1'b0;
            r_rd_select   <= 4'd0;
            r_pkt_len     <= 9'd0;
            r_pkt_chan    <= 5'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant && w_grant_cmd) begin
                r_rd_select <= 4'(NUM_CHAN);
                r_pkt_len   <= w_cmd_len;
                r_pkt_chan  <= 5'h1F;
                r_cmd_burst <= (r_cmd_burst == 3'd7) ? 3'd7 : r_cmd_burst + 3'd1;
            end else if (w_grant) begin
                r_rd_select <= {2'b00, w_rr_idx};
                r_pkt_len   <= 9'(PAYLOAD_WORDS);
                r_pkt_chan  <= {3'b000, w_rr_idx};
                r_rr_ptr    <= w_rr_nxt;
                r_cmd_burst <= 3'd0;
            end
            if (r_state == START) begin
                r_wd <= 10'd0;
            end else if (r_state == WAIT) begin
                r_wd <= r_wd + 10'd1;
            end
            r_hold <= (r_state == HOLD) && !r_hold;
            if (w_wd_expire) begin
                r_timeout_err <= 1'b1;
            end else if (bus.clear_status) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign bus.rd_select   = r_rd_select;
    assign bus.pkt_len     = r_pkt_len;
    assign bus.pkt_chan    = r_pkt_chan;
    assign bus.pkt_start   = (r_state == START);
    assign bus.busy        = (r_state == START) || (r_state == WAIT);
    assign bus.timeout_err = r_timeout_err;
    assign bus.debug       = {r_state, r_rr_ptr, r_cmd_burst};
endmodule

// File: tb/tb_rx_pkt_scheduler.sv
// Scoreboard bench for rx_pkt_scheduler with NUM_CHAN=2: expected grants are queued as
// stimulus is set up and compared whenever the scheduler pulses pkt_start.
module tb_rx_pkt_scheduler;
    localparam int NC = 2;

    typedef struct {
        logic [3:0] sel;
        logic [8:0] len;
        logic [4:0] chan;
        logic [1:0] rr;
        logic [2:0] burst;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   n_starts;
    int   m_rr;
    int   m_burst;
    int   n0;
    exp_t sb_q[$];

    rx_pkt_scheduler_if #(.NUM_CHAN(NC)) bus ();

    rx_pkt_scheduler #(.NUM_CHAN(NC)) dut (
        .rxclk (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_usedw(input int k, input int v);
        bus.chan_usedw[10*k +: 10] = 10'(v);
    endtask

    task automatic push_cmd(input int len);
        exp_t e;
        m_burst = (m_burst >= 7) ? 7 : m_burst + 1;
        e.sel = 4'(NC); e.len = 9'(len); e.chan = 5'h1F; e.rr = 2'(m_rr); e.burst = 3'(m_burst);
        sb_q.push_back(e);
    endtask

    task automatic push_data(input int k);
        exp_t e;
        m_burst = 0;
        m_rr    = (k + 1) % NC;
        e.sel = 4'(k); e.len = 9'd252; e.chan = 5'(k); e.rr = 2'(m_rr); e.burst = 3'd0;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.enable       = 1'b0;
        bus.have_space   = 1'b0;
        bus.pkt_done     = 1'b0;
        bus.clear_status = 1'b0;
        bus.chan_usedw   = '0;
        bus.chan_empty   = '1;
        repeat (3) cyc();
        reset   = 1'b0;
        m_rr    = 0;
        m_burst = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   32'(bus.rd_select),   0);
        check({tag, "_start"}, 32'(bus.pkt_start),   0);
        check({tag, "_len"},   32'(bus.pkt_len),     0);
        check({tag, "_chan"},  32'(bus.pkt_chan),    0);
        check({tag, "_busy"},  32'(bus.busy),        0);
        check({tag, "_terr"},  32'(bus.timeout_err), 0);
        check({tag, "_dbg"},   32'(bus.debug),       0);
    endtask

    task automatic wait_start(input string tag, input int budget);
        int i;
        i = 0;
        while (bus.pkt_start !== 1'b1 && i < budget) begin
            cyc();
            i++;
        end
        check({tag, "_seen"}, 32'(bus.pkt_start), 1);
    endtask

    task automatic finish_pkt(input string tag, input int delay);
        repeat (delay) cyc();
        check({tag, "_busy_wait"}, 32'(bus.busy), 1);
        bus.pkt_done = 1'b1;
        cyc();
        bus.pkt_done = 1'b0;
        check({tag, "_busy_hold"}, 32'(bus.busy), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.pkt_start === 1'b1) begin
            n_starts++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_start", 32'(bus.pkt_start), 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_sel",   32'(bus.rd_select),   32'(e.sel));
                check("sb_len",   32'(bus.pkt_len),     32'(e.len));
                check("sb_chan",  32'(bus.pkt_chan),    32'(e.chan));
                check("sb_rr",    32'(bus.debug[4:3]),  32'(e.rr));
                check("sb_burst", 32'(bus.debug[2:0]),  32'(e.burst));
                check("sb_state", 32'(bus.debug[7:5]),  2);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_starts = 0;

        // Reset state
        do_reset();
        check_all_zero("rst");

        // Round robin across two data channels, command empty
        set_usedw(0, 252);
        set_usedw(1, 300);
        bus.chan_empty = 3'b100;
        push_data(0);
        push_data(1);
        bus.enable     = 1'b1;
        bus.have_space = 1'b1;
        wait_start("rr0", 20);
        finish_pkt("rr0", 3);
        wait_start("rr1", 20);
        set_usedw(0, 0);
        set_usedw(1, 0);
        finish_pkt("rr1", 3);
        repeat (4) cyc();
        check("rr_hold_sel", 32'(bus.rd_select), 1);
        check("rr_hold_len", 32'(bus.pkt_len), 252);
        check("rr_ptr_back", 32'(bus.debug[4:3]), 0);
        check("rr_park_arb", 32'(bus.debug[7:5]), 1);
        bus.have_space = 1'b0;
        cyc();
        check("rr_back_idle", 32'(bus.debug[7:5]), 0);

        // Command grant and two-cycle latency from have_space
        set_usedw(NC, 10);
        bus.chan_empty[NC] = 1'b0;
        push_cmd(10);
        repeat (3) cyc();
        bus.have_space = 1'b1;
        cyc();
        check("cmd_lat1", 32'(bus.pkt_start), 0);
        cyc();
        check("cmd_lat2", 32'(bus.pkt_start), 1);
        bus.chan_empty[NC] = 1'b1;
        finish_pkt("cmd", 2);

        // Command burst limit against an always-eligible ch0
        do_reset();
        set_usedw(NC, 300);
        set_usedw(0, 252);
        bus.chan_empty = 3'b000;
        bus.enable     = 1'b1;
        bus.have_space = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) push_data(0);
            else push_cmd(252);
        end
        for (int i = 0; i < 10; i++) begin
            wait_start("burst", 20);
            if (i == 9) begin
                bus.chan_empty[NC] = 1'b1;
                set_usedw(0, 0);
            end
            finish_pkt("burst", 1);
        end

        // Command-only grants: minimum length 1 and cmd_burst saturation at 7
        set_usedw(NC, 0);
        bus.chan_empty[NC] = 1'b0;
        push_cmd(1);
        for (int i = 0; i < 7; i++) push_cmd(5);
        for (int i = 0; i < 8; i++) begin
            wait_start("sat", 20);
            set_usedw(NC, 5);
            finish_pkt("sat", 1);
        end

        // Saturated burst: the eligible data channel wins over the command
        set_usedw(1, 252);
        push_data(1);
        wait_start("burst_data", 20);
        set_usedw(1, 0);
        bus.chan_empty[NC] = 1'b1;
        finish_pkt("burst_data", 1);

        // Watchdog expiry, sticky flag and clear_status
        set_usedw(0, 252);
        push_data(0);
        wait_start("to", 20);
        set_usedw(0, 0);
        bus.have_space = 1'b0;
        repeat (1023) cyc();
        check("to_before_terr", 32'(bus.timeout_err), 0);
        check("to_before_busy", 32'(bus.busy), 1);
        cyc();
        check("to_at_terr", 32'(bus.timeout_err), 1);
        check("to_at_busy", 32'(bus.busy), 0);
        repeat (2) cyc();
        check("to_idle", 32'(bus.debug[7:5]), 0);
        check("to_sticky", 32'(bus.timeout_err), 1);
        bus.clear_status = 1'b1;
        cyc();
        bus.clear_status = 1'b0;
        check("to_cleared", 32'(bus.timeout_err), 0);

        // have_space low blocks a heavily filled channel; raising it grants two cycles later
        set_usedw(0, 1000);
        n0 = n_starts;
        repeat (10) cyc();
        check("nospace_starts", 32'(n_starts - n0), 0);
        push_data(0);
        bus.have_space = 1'b1;
        cyc();
        check("space_lat1", 32'(bus.pkt_start), 0);
        cyc();
        check("space_lat2", 32'(bus.pkt_start), 1);

        // Same packet: enable drops mid-WAIT, pkt_done lands on the expiry cycle
        repeat (5) cyc();
        bus.enable = 1'b0;
        repeat (1018) cyc();
        bus.pkt_done = 1'b1;
        cyc();
        bus.pkt_done = 1'b0;
        check("edge_terr", 32'(bus.timeout_err), 0);
        check("edge_busy", 32'(bus.busy), 0);
        repeat (2) cyc();
        check("edge_park_idle", 32'(bus.debug[7:5]), 0);

        // Reset while WAITing, then a stray pkt_done
        push_data(0);
        bus.enable = 1'b1;
        wait_start("rstw", 20);
        repeat (5) cyc();
        reset          = 1'b1;
        bus.have_space = 1'b0;
        cyc();
        check_all_zero("rstw");
        reset   = 1'b0;
        m_rr    = 0;
        m_burst = 0;
        bus.pkt_done = 1'b1;
        cyc();
        bus.pkt_done = 1'b0;
        n0 = n_starts;
        repeat (5) cyc();
        check("rstw_no_start", 32'(n_starts - n0), 0);
        check("rstw_dbg", 32'(bus.debug), 0);

        check("sb_drained", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
